irom_arbiter: RTL and testbench
===============================

Name: irom_arbiter

Overview:
- Shares the single 64 KB program ROM (word-addressed, 14-bit address, combinational read) between two requesters:
  - the CPU instruction-fetch port;
  - a debug/loader read port, e.g. a UART debug monitor dumping program memory.
- Sits between the requesters and the ROM instance.
- Grants one requester per cycle and registers the ROM word into a one-cycle-latency response routed back to the granted requester.
- Fetch has priority, with a bounded-starvation guarantee for the debug port.

Parameters:
- ADDR_W, 14, ROM word-address width (ROM covers byte addresses 0 .. 2^(ADDR_W+2)-1).
- STARVE_MAX, 4, maximum consecutive fetch grants while debug is waiting before debug is forced through (range 1..15).
- ERR_WORD, 32'h0000_0013, data returned on an error response (RV32I NOP).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- if_req  in  1  fetch request
- if_addr  in  32  fetch byte address
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  fetch response valid
- if_rdata  out  32  fetch response word
- if_err  out  1  fetch response is an error
- dbg_req  in  1  debug request
- dbg_addr  in  32  debug byte address
- dbg_gnt  out  1  debug request accepted this cycle
- dbg_rvalid  out  1  debug response valid
- dbg_rdata  out  32  debug response word
- dbg_err  out  1  debug response is an error
- rom_addr  out  ADDR_W  ROM word address (byte address [ADDR_W+1:2])
- rom_rdata  in  32  ROM word (combinational from rom_addr)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - all *_rvalid, *_err = 0; *_rdata = 0;
  - starvation counter = 0; owner register = NONE.
  - rom_addr = 0 while no grant is made.
- Handshake:
  - A requester raises req with a stable addr and holds both until gnt is seen high in the same cycle.
  - gnt is combinational from req and the arbitration state.
  - The transaction is accepted on the rising edge where req && gnt.
- Latency:
  - A request accepted at edge N produces rvalid=1 with rdata/err during cycle N+1 (registered), for exactly one cycle.
  - Back-to-back accepts give one response per cycle, i.e. full throughput.
- Arbitration, evaluated each cycle:
  - Only if_req: if_gnt=1.
  - Only dbg_req: dbg_gnt=1.
  - Both, and starve_cnt < STARVE_MAX: if_gnt=1; starve_cnt increments.
  - Both, and starve_cnt == STARVE_MAX: dbg_gnt=1.
  - Counter clears on any debug grant and whenever dbg_req=0. It saturates and never wraps.
  - if_gnt and dbg_gnt are never both 1.
- rom_addr is driven from the granted requester's addr[ADDR_W+1:2]; otherwise it holds 0.
- Owner register: records which port was granted, and the response is steered only to that port. The other port's rvalid stays 0.
- Error rules, computed at grant and registered with the data:
  - out-of-range: addr[31:ADDR_W+2] != 0 → err=1, rdata=ERR_WORD;
  - misaligned: addr[1:0] != 0 → err=1, rdata=ERR_WORD.
  - Otherwise err=0 and rdata = rom_rdata.
  - An erroring request still consumes its grant slot.
- Reset mid-operation: an in-flight response is dropped. No rvalid is seen after rst deasserts until a new grant is made.
- Requests asserted during reset are not granted; gnt=0 while rst=1.

Decomposition:
- Shared package (irom_pkg):
  - owner encoding (NONE/IF/DBG);
  - ERR_WORD default;
  - ROM ADDR_W constant, also used by the ROM wrapper.
- One natural sub-module: irom_req_check (combinational range/alignment checker, instantiated once per port).
- The starvation counter stays inline.

Test Plan:
1. Reset, then if_req held high with if_addr=0,4,8,… advancing on each gnt → if_gnt=1 every cycle; if_rvalid every cycle from the second; if_rdata = ROM words 0,1,2; dbg_rvalid=0 throughout.
2. dbg_req alone, dbg_addr=32'h0000_0100 → dbg_gnt same cycle; next cycle dbg_rvalid=1, dbg_rdata = ROM word 64, dbg_err=0.
3. Both requesting continuously, STARVE_MAX=4 → grant sequence IF,IF,IF,IF,DBG repeating; each response lands on the matching port one cycle later.
4. if_addr=32'h0001_0000 → if_err=1 and if_rdata=32'h0000_0013 next cycle. Then dbg_addr=32'h0000_0006 → dbg_err=1 and dbg_rdata=ERR_WORD.
5. rst pulsed for one cycle between an accepted fetch and its response → no if_rvalid after reset; counter=0; the next request is granted normally.
6. dbg_req drops after 2 starved cycles and re-asserts → counter restarts from 0, so 4 further fetch grants occur before debug is served.

Source files
------------

// File: rtl/irom_pkg.sv
// Shared definitions for the program-ROM arbiter: owner encoding and ROM geometry.
package irom_pkg;

  localparam int IROM_ADDR_W = 14;
  localparam logic [31:0] IROM_ERR_WORD = 32'h0000_0013;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DBG  = 2'd2
  } owner_t;

endpackage

// File: rtl/irom_arbiter_if.sv
// Bus bundle between the fetch/debug requesters, the arbiter and the program ROM.
interface irom_arbiter_if #(
  parameter int ADDR_W = irom_pkg::IROM_ADDR_W
);
  logic              if_req;
  logic [31:0]       if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [31:0]       if_rdata;
  logic              if_err;

  logic              dbg_req;
  logic [31:0]       dbg_addr;
  logic              dbg_gnt;
  logic              dbg_rvalid;
  logic [31:0]       dbg_rdata;
  logic              dbg_err;

  logic [ADDR_W-1:0] rom_addr;
  logic [31:0]       rom_rdata;

  // The requesters and the ROM together form the master side; the arbiter is the slave.
  modport master (
    output if_req, if_addr, dbg_req, dbg_addr, rom_rdata,
    input  if_gnt, if_rvalid, if_rdata, if_err,
    input  dbg_gnt, dbg_rvalid, dbg_rdata, dbg_err, rom_addr
  );

  modport slave (
    input  if_req, if_addr, dbg_req, dbg_addr, rom_rdata,
    output if_gnt, if_rvalid, if_rdata, if_err,
    output dbg_gnt, dbg_rvalid, dbg_rdata, dbg_err, rom_addr
  );
endinterface

// File: rtl/irom_req_check.sv
// Flags a byte address that is misaligned or lies beyond the end of the program ROM.
module irom_req_check #(
  parameter int ADDR_W = irom_pkg::IROM_ADDR_W
) (
  input  logic [31:0] addr,
  output logic        err
);
  // Every bit outside the word-index field [ADDR_W+1:2] must be zero.
  localparam logic [31:0] BAD_MASK = ~(((32'd1 << ADDR_W) - 32'd1) << 2);

  assign err = |(addr & BAD_MASK);
endmodule

// File: rtl/irom_arbiter.sv
// Two-port program-ROM arbiter: fetch has priority, debug is forced through after STARVE_MAX losses.
module irom_arbiter
  import irom_pkg::*;
#(
  parameter int          ADDR_W     = IROM_ADDR_W,
  parameter int          STARVE_MAX = 4,
  parameter logic [31:0] ERR_WORD   = IROM_ERR_WORD
) (
  input logic           clk,
  input logic           rst,
  irom_arbiter_if.slave bus
);
  logic [3:0]  starve_cnt;
  logic        starved;
  owner_t      owner;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        if_bad;
  logic        dbg_bad;
  logic        sel_bad;

  irom_req_check #(.ADDR_W(ADDR_W)) u_if_check  (.addr(bus.if_addr),  .err(if_bad));
  irom_req_check #(.ADDR_W(ADDR_W)) u_dbg_check (.addr(bus.dbg_addr), .err(dbg_bad));

  assign starved     = (starve_cnt == 4'(STARVE_MAX));
  assign bus.if_gnt  = !rst && bus.if_req && !(bus.dbg_req && starved);
  assign bus.dbg_gnt = !rst && bus.dbg_req && (!bus.if_req || starved);

  always_comb begin
    bus.rom_addr = '0;
    sel_bad      = 1'b0;
    if (bus.if_gnt) begin
      bus.rom_addr = bus.if_addr[ADDR_W+1:2];
      sel_bad      = if_bad;
    end else if (bus.dbg_gnt) begin
      bus.rom_addr = bus.dbg_addr[ADDR_W+1:2];
      sel_bad      = dbg_bad;
    end
  end

  // The counter only tracks fetch wins while debug is actually waiting, so it saturates at STARVE_MAX.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
      owner      <= OWN_NONE;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      if (!bus.dbg_req || bus.dbg_gnt)
        starve_cnt <= '0;
      else if (bus.if_gnt && !starved)
        starve_cnt <= starve_cnt + 4'd1;

      if (bus.if_gnt)
        owner <= OWN_IF;
      else if (bus.dbg_gnt)
        owner <= OWN_DBG;
      else
        owner <= OWN_NONE;

      if (bus.if_gnt || bus.dbg_gnt) begin
        err_q   <= sel_bad;
        rdata_q <= sel_bad ? ERR_WORD : bus.rom_rdata;
      end
    end
  end

  assign bus.if_rvalid  = (owner == OWN_IF);
  assign bus.if_rdata   = bus.if_rvalid ? rdata_q : '0;
  assign bus.if_err     = bus.if_rvalid && err_q;
  assign bus.dbg_rvalid = (owner == OWN_DBG);
  assign bus.dbg_rdata  = bus.dbg_rvalid ? rdata_q : '0;
  assign bus.dbg_err    = bus.dbg_rvalid && err_q;
endmodule

// File: tb/tb_irom_arbiter.sv
// Scoreboard bench for irom_arbiter: directed request vectors, expected responses queued per port.
module tb_irom_arbiter;
  import irom_pkg::*;

  typedef struct {
    int          cyc;
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  exp_t if_q[$];
  exp_t dbg_q[$];
  logic [31:0] ia;
  logic [31:0] da;

  irom_arbiter_if #(.ADDR_W(14)) bus ();

  irom_arbiter #(.ADDR_W(14), .STARVE_MAX(4), .ERR_WORD(32'h0000_0013)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] rom_word(input logic [13:0] w);
    return 32'hC0DE_0000 ^ (32'(w) * 32'h0001_0101);
  endfunction

  always_comb bus.rom_rdata = rom_word(bus.rom_addr);

  // Independent reference: 64 KB ROM, word aligned, NOP on any error.
  function automatic exp_t model(input logic [31:0] a, input int c);
    exp_t e;
    e.cyc  = c;
    e.err  = (a[31:16] != 16'h0) || (a[1:0] != 2'b00);
    e.data = e.err ? 32'h0000_0013 : rom_word(a[15:2]);
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input string name, input logic ifr, input logic [31:0] ifa,
                               input logic dr, input logic [31:0] dba,
                               input logic exp_if, input logic exp_dbg);
    bus.if_req   = ifr;
    bus.if_addr  = ifa;
    bus.dbg_req  = dr;
    bus.dbg_addr = dba;
    @(negedge clk);
    checkOutput({name, "_if_gnt"}, 32'(bus.if_gnt), 32'(exp_if));
    checkOutput({name, "_dbg_gnt"}, 32'(bus.dbg_gnt), 32'(exp_dbg));
    if (ifr && bus.if_gnt) if_q.push_back(model(ifa, cyc + 1));
    if (dr && bus.dbg_gnt) dbg_q.push_back(model(dba, cyc + 1));
    @(posedge clk);
    #1;
  endtask

  // Monitors: every response must match the oldest expectation and arrive in its cycle.
  always @(negedge clk) begin
    exp_t e;
    if (bus.if_rvalid) begin
      if (if_q.size() == 0) checkOutput("if_unexpected_rvalid", 32'd1, 32'd0);
      else begin
        e = if_q.pop_front();
        checkOutput("if_resp_cycle", 32'(cyc), 32'(e.cyc));
        checkOutput("if_rdata", bus.if_rdata, e.data);
        checkOutput("if_err", 32'(bus.if_err), 32'(e.err));
      end
    end else if (if_q.size() > 0 && if_q[0].cyc <= cyc) begin
      void'(if_q.pop_front());
      checkOutput("if_missing_rvalid", 32'd0, 32'd1);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (bus.dbg_rvalid) begin
      if (dbg_q.size() == 0) checkOutput("dbg_unexpected_rvalid", 32'd1, 32'd0);
      else begin
        e = dbg_q.pop_front();
        checkOutput("dbg_resp_cycle", 32'(cyc), 32'(e.cyc));
        checkOutput("dbg_rdata", bus.dbg_rdata, e.data);
        checkOutput("dbg_err", 32'(bus.dbg_err), 32'(e.err));
      end
    end else if (dbg_q.size() > 0 && dbg_q[0].cyc <= cyc) begin
      void'(dbg_q.pop_front());
      checkOutput("dbg_missing_rvalid", 32'd0, 32'd1);
    end
  end

  initial begin
    rst          = 1'b1;
    bus.if_req   = 1'b1;
    bus.if_addr  = 32'h0;
    bus.dbg_req  = 1'b1;
    bus.dbg_addr = 32'h0;
    @(negedge clk);
    checkOutput("reset_if_gnt", 32'(bus.if_gnt), 32'd0);
    checkOutput("reset_dbg_gnt", 32'(bus.dbg_gnt), 32'd0);
    checkOutput("reset_if_rdata", bus.if_rdata, 32'd0);
    checkOutput("reset_dbg_err", 32'(bus.dbg_err), 32'd0);
    checkOutput("reset_rom_addr", 32'(bus.rom_addr), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus("idle", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);

    $display("[TB] streaming fetch");
    ia = 32'h0;
    for (int k = 0; k < 4; k++) begin
      applyStimulus("fetch", 1'b1, ia, 1'b0, 32'h0, 1'b1, 1'b0);
      ia += 32'd4;
    end

    $display("[TB] debug alone");
    applyStimulus("dbg_only", 1'b0, 32'h0, 1'b1, 32'h0000_0100, 1'b0, 1'b1);
    applyStimulus("idle", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);

    $display("[TB] contention");
    ia = 32'h200;
    da = 32'h300;
    for (int k = 0; k < 10; k++) begin
      applyStimulus("both", 1'b1, ia, 1'b1, da, (k % 5) != 4, (k % 5) == 4);
      if ((k % 5) == 4) da += 32'd4;
      else ia += 32'd4;
    end
    applyStimulus("idle", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);

    $display("[TB] error and boundary addresses");
    applyStimulus("if_range", 1'b1, 32'h0001_0000, 1'b0, 32'h0, 1'b1, 1'b0);
    applyStimulus("dbg_misal", 1'b0, 32'h0, 1'b1, 32'h0000_0006, 1'b0, 1'b1);
    applyStimulus("if_last", 1'b1, 32'h0000_FFFC, 1'b0, 32'h0, 1'b1, 1'b0);
    applyStimulus("if_high", 1'b1, 32'h8000_0004, 1'b0, 32'h0, 1'b1, 1'b0);
    applyStimulus("idle", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);

    $display("[TB] reset mid-flight");
    ia = 32'h40;
    for (int k = 0; k < 3; k++) begin
      applyStimulus("pre_rst", 1'b1, ia, 1'b1, 32'h80, 1'b1, 1'b0);
      ia += 32'd4;
    end
    rst = 1'b1;
    if_q.delete();
    dbg_q.delete();
    @(negedge clk);
    checkOutput("mid_rst_if_gnt", 32'(bus.if_gnt), 32'd0);
    checkOutput("mid_rst_if_rvalid", 32'(bus.if_rvalid), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      applyStimulus("post_rst", 1'b1, ia, 1'b1, 32'h80, k != 4, k == 4);
      if (k != 4) ia += 32'd4;
    end
    applyStimulus("idle", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);

    $display("[TB] debug withdraw restarts counter");
    ia = 32'h1000;
    applyStimulus("starve1", 1'b1, ia, 1'b1, 32'h500, 1'b1, 1'b0);
    ia += 32'd4;
    applyStimulus("starve2", 1'b1, ia, 1'b1, 32'h500, 1'b1, 1'b0);
    ia += 32'd4;
    applyStimulus("withdraw", 1'b1, ia, 1'b0, 32'h0, 1'b1, 1'b0);
    ia += 32'd4;
    for (int k = 0; k < 5; k++) begin
      applyStimulus("restart", 1'b1, ia, 1'b1, 32'h500, k != 4, k == 4);
      if (k != 4) ia += 32'd4;
    end

    for (int k = 0; k < 3; k++)
      applyStimulus("drain", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("if_q_drained", 32'(if_q.size()), 32'd0);
    checkOutput("dbg_q_drained", 32'(dbg_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
